// File: rtl/leiwand_rv32_wb_decoder.sv
// leiwand_rv32_wb_decoder: one-master Wishbone address decoder with per-slave routing and error acks
// Define LEIWAND_WB_DECODER_STATS_EN to add the saturating err_count output.
module leiwand_rv32_wb_decoder #(
  parameter int MEM_WIDTH = 32,
  parameter int NUM_SLAVES = 4,
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_BASES = {32'h0, 32'h0, 32'h20400000, 32'h10000000},
  parameter logic [NUM_SLAVES*MEM_WIDTH-1:0] SLAVE_SIZES = {32'h0, 32'h0, 32'h4000, 32'h4000},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wb_cyc,
  input  logic                            wb_stb,
  input  logic                            wb_we,
  input  logic [MEM_WIDTH-1:0]            wb_addr,
  input  logic [MEM_WIDTH-1:0]            wb_data_out,
  input  logic [2:0]                      data_write_size,
  output logic                            wb_ack,
  output logic                            wb_err,
  output logic                            wb_stall,
  output logic [MEM_WIDTH-1:0]            wb_data_in,
  output logic [NUM_SLAVES-1:0]           s_stb,
  output logic [NUM_SLAVES-1:0]           s_cyc,
  output logic                            s_we,
  output logic [MEM_WIDTH-1:0]            s_addr,
  output logic [MEM_WIDTH-1:0]            s_data_out,
  output logic [2:0]                      s_size,
  input  logic [NUM_SLAVES-1:0]           s_ack,
  input  logic [NUM_SLAVES-1:0]           s_stall,
  input  logic [NUM_SLAVES*MEM_WIDTH-1:0] s_data_in
`ifdef LEIWAND_WB_DECODER_STATS_EN
  , output logic [15:0]                   err_count
`endif
);
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, BUSY, ERR} state_t;
  state_t state;
  logic [IW-1:0] sel, hit_idx;
  logic [15:0] cnt;
  logic [NUM_SLAVES-1:0] hits;
  logic [MEM_WIDTH:0] win_base [NUM_SLAVES];
  logic [MEM_WIDTH:0] win_size [NUM_SLAVES];
  logic req, idle, busy, fwd;
  // Offset compare in MEM_WIDTH+1 bits: addresses below a base wrap above 2^MEM_WIDTH and miss
  for (genvar k = 0; k < NUM_SLAVES; k++) begin : g_dec
    assign win_base[k] = {1'b0, SLAVE_BASES[k*MEM_WIDTH +: MEM_WIDTH]};
    assign win_size[k] = {1'b0, SLAVE_SIZES[k*MEM_WIDTH +: MEM_WIDTH]};
    assign hits[k] = ({1'b0, wb_addr} - win_base[k]) < win_size[k];
  end
  always_comb begin
    hit_idx = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) hit_idx = hits[k] ? IW'(k) : hit_idx;
  end
  assign req = wb_cyc & wb_stb;
  assign idle = state == IDLE;
  assign busy = state == BUSY;
  assign fwd = busy & s_ack[sel];
  assign s_stb = (idle && req && |hits) ? NUM_SLAVES'(1) << hit_idx : '0;
  assign s_cyc = (busy && wb_cyc) ? NUM_SLAVES'(1) << sel : s_stb;
  assign wb_stall = !idle || (req && |hits && s_stall[hit_idx]);
  assign wb_ack = fwd || state == ERR;
  assign wb_data_in = fwd ? s_data_in[sel*MEM_WIDTH +: MEM_WIDTH] : '0;
  assign s_we = wb_we;
  assign s_addr = wb_addr;
  assign s_data_out = wb_data_out;
  assign s_size = data_write_size;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      sel <= '0;
      cnt <= '0;
      wb_err <= 1'b0;
    end else begin
      wb_err <= 1'b0;
      case (state)
        IDLE:
          if (req && !(|hits)) begin
            state <= ERR;
            wb_err <= 1'b1;
          end else if (req && !s_stall[hit_idx]) begin
            state <= BUSY;
            sel <= hit_idx;
            cnt <= '0;
          end
        BUSY:
          if (!wb_cyc || s_ack[sel]) begin
            state <= IDLE;
            cnt <= '0;
          end else if (cnt == LAST) begin
            state <= ERR;
            wb_err <= 1'b1;
          end else cnt <= cnt + 16'd1;
        default: state <= IDLE;
      endcase
    end
`ifdef LEIWAND_WB_DECODER_STATS_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) err_count <= '0;
    else if (state == ERR && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`endif
endmodule

// File: tb/tb_leiwand_rv32_wb_decoder.sv
// tb_leiwand_rv32_wb_decoder: randomized transactions checked against a transaction-level decoder model
// Honours LEIWAND_WB_DECODER_STATS_EN to also track err_count.
module tb_leiwand_rv32_wb_decoder;
  localparam int MW = 32, NS = 4, TO = 8;
  localparam logic [NS*MW-1:0] BASES = {32'hFFFFF000, 32'h10002000, 32'h20400000, 32'h10000000};
  localparam logic [NS*MW-1:0] SIZES = {32'h1000, 32'h4000, 32'h4000, 32'h4000};
  logic clk = 0, reset = 1;
  logic wb_cyc = 0, wb_stb = 0, wb_we = 0;
  logic [MW-1:0] wb_addr = '0, wb_data_out = '0;
  logic [2:0] data_write_size = 3'd4;
  logic wb_ack, wb_err, wb_stall, s_we;
  logic [MW-1:0] wb_data_in, s_addr, s_data_out;
  logic [NS-1:0] s_stb, s_cyc, s_ack = '0, s_stall = '0;
  logic [2:0] s_size;
  logic [NS*MW-1:0] s_data_in = '0;
`ifdef LEIWAND_WB_DECODER_STATS_EN
  logic [15:0] err_count;
`endif
  int n_vec = 0, n_bad = 0, exp_errs = 0;
  longint bases [NS] = '{64'h10000000, 64'h20400000, 64'h10002000, 64'hFFFFF000};
  longint sizes [NS] = '{64'h4000, 64'h4000, 64'h4000, 64'h1000};
  always #5 clk = ~clk;
  leiwand_rv32_wb_decoder #(
    .MEM_WIDTH(MW), .NUM_SLAVES(NS), .SLAVE_BASES(BASES), .SLAVE_SIZES(SIZES), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data_out(wb_data_out), .data_write_size(data_write_size), .wb_ack(wb_ack), .wb_err(wb_err),
    .wb_stall(wb_stall), .wb_data_in(wb_data_in), .s_stb(s_stb), .s_cyc(s_cyc), .s_we(s_we),
    .s_addr(s_addr), .s_data_out(s_data_out), .s_size(s_size), .s_ack(s_ack), .s_stall(s_stall),
    .s_data_in(s_data_in)
`ifdef LEIWAND_WB_DECODER_STATS_EN
    , .err_count(err_count)
`endif
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int decode(input logic [31:0] a);
    for (int k = 0; k < NS; k++)
      if (sizes[k] != 0 && longint'(a) >= bases[k] && longint'(a) < bases[k] + sizes[k]) return k;
    return -1;
  endfunction
  function automatic logic [31:0] pick_addr();
    int k;
    k = $urandom_range(NS - 1);
    case ($urandom_range(6))
      0: return 32'(bases[k]);
      1: return 32'(bases[k] + sizes[k] - 1);
      2: return 32'(bases[k] + sizes[k]);
      3: return 32'(bases[k] - 1);
      4, 5: return 32'(bases[k]) + $urandom_range(32'(sizes[k]) - 1);
      default: return $urandom;
    endcase
  endfunction
  task automatic idle_cycle();
    @(negedge clk);
    wb_cyc = 0; wb_stb = 0; s_ack = '0; s_stall = '0;
    #2;
    check("idle_ctl", 32'({wb_ack, wb_err, wb_stall, s_stb, s_cyc}), 32'h0);
    check("idle_data", wb_data_in, 32'h0);
`ifdef LEIWAND_WB_DECODER_STATS_EN
    check("err_count", 32'(err_count), 32'(exp_errs));
`endif
  endtask
  task automatic accept(input logic [31:0] a);
    @(negedge clk);
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = a; s_ack = '0; s_stall = '0;
    #2;
    check("acc_stb", 32'(s_stb), 32'(1) << decode(a));
  endtask
  // lat: BUSY cycles before the slave acks (-1 = never); spur: non-target slaves acking meanwhile
  task automatic txn(input logic [31:0] a, input logic we, input int stalls, input int lat,
                     input logic [NS-1:0] spur, input logic [31:0] rd);
    int k;
    logic [NS-1:0] tgt;
    logic [31:0] wd;
    logic [2:0] sz;
    k = decode(a);
    tgt = k < 0 ? '0 : NS'(1) << k;
    wd = $urandom;
    sz = 3'(1 << $urandom_range(2));
    if (k < 0) stalls = 0;
    for (int i = 0; i <= stalls; i++) begin
      @(negedge clk);
      wb_cyc = 1; wb_stb = 1; wb_we = we; wb_addr = a; wb_data_out = wd; data_write_size = sz;
      s_ack = '0;
      s_stall = NS'($urandom) & ~tgt | (i < stalls ? tgt : '0);
      #2;
      check("req_stb", 32'(s_stb), 32'(tgt));
      check("req_stall", 32'(wb_stall), 32'(i < stalls));
      check("req_ack", 32'(wb_ack), 32'h0);
      check("bc_ctl", 32'({s_we, s_size}), 32'({we, sz}));
      check("bc_addr", s_addr, a);
      check("bc_data", s_data_out, wd);
    end
    if (k < 0) begin
      @(negedge clk);
      wb_stb = 0; s_stall = '0;
      #2;
      check("err_ack", 32'({wb_ack, wb_err, wb_stall}), 32'h7);
      check("err_data", wb_data_in, 32'h0);
      exp_errs++;
    end else begin
      for (int c = 0; c <= TO; c++) begin
        @(negedge clk);
        wb_stb = 0; s_stall = '0;
        s_ack = spur & ~tgt | (c == lat ? tgt : '0);
        s_data_in = {$urandom, $urandom, $urandom, $urandom};
        s_data_in[k*MW +: MW] = rd;
        #2;
        if (c == lat) begin
          check("ack", 32'({wb_ack, wb_err}), 32'h2);
          check("rdata", wb_data_in, rd);
          break;
        end
        if (c == TO) begin
          check("tmo_ack", 32'({wb_ack, wb_err, wb_stall}), 32'h7);
          check("tmo_data", wb_data_in, 32'h0);
          exp_errs++;
        end else begin
          check("busy", 32'({wb_ack, wb_stall, s_stb}), 32'h10);
          check("busy_cyc", 32'(s_cyc), 32'(tgt));
          check("busy_data", wb_data_in, 32'h0);
        end
      end
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] a;
    #2;
    check("rst_ctl", 32'({wb_ack, wb_err, wb_stall, s_stb, s_cyc}), 32'h0);
    check("rst_data", wb_data_in, 32'h0);
    @(negedge clk);
    reset = 0;
    idle_cycle();
    txn(32'h10000010, 0, 0, 1, '0, 32'hDEADBEEF); idle_cycle();
    txn(32'h20400004, 1, 3, 0, '0, 32'h00000000); idle_cycle();
    txn(32'h30000000, 0, 0, 0, '0, 32'h00000000); idle_cycle();
    txn(32'h10000000, 0, 0, -1, '0, 32'h00000000);
    txn(32'h10000004, 0, 0, 0, '0, 32'hCAFEF00D); idle_cycle();
    txn(32'h10000100, 0, 0, 3, 4'b0010, 32'h12345678); idle_cycle();
    txn(32'h10000100, 0, 0, TO - 1, 4'b1110, 32'h0BADF00D); idle_cycle();
    txn(32'hFFFFFFFF, 0, 0, 0, '0, 32'h11112222);
    txn(32'h10002000, 0, 0, 0, '0, 32'h33334444);
    txn(32'h10004000, 0, 0, 0, '0, 32'h55556666);
    txn(32'h10006000, 0, 0, 0, '0, 32'h0); idle_cycle();
    accept(32'h20400010);
    @(negedge clk); wb_cyc = 0; wb_stb = 0; #2;
    check("drop_noack", 32'({wb_ack, wb_err}), 32'h0);
    idle_cycle();
    accept(32'h20400010);
    @(negedge clk); wb_cyc = 0; wb_stb = 0; s_ack = 4'b0010; s_data_in[MW +: MW] = 32'h5A5A1234; #2;
    check("drop_fwd", 32'({wb_ack, wb_err}), 32'h2);
    check("drop_data", wb_data_in, 32'h5A5A1234);
    idle_cycle();
    accept(32'h10000000);
    @(negedge clk); wb_stb = 0;
    #1 reset = 1;
    #1 check("arst_ctl", 32'({wb_ack, wb_err, wb_stall}), 32'h0);
    #1 reset = 0;
    @(negedge clk); s_ack = 4'b0001; s_data_in[0 +: MW] = 32'hFEEDFACE; #2;
    check("arst_noack", 32'({wb_ack, wb_err, wb_stall}), 32'h0);
    check("arst_data", wb_data_in, 32'h0);
    idle_cycle();
    txn(32'h10000008, 0, 0, 2, '0, 32'h87654321); idle_cycle();
    for (int n = 0; n < 200; n++) begin
      a = pick_addr();
      txn(a, 1'($urandom), $urandom_range(3), $urandom_range(7) == 0 ? -1 : int'($urandom_range(4)),
          NS'($urandom) & {NS{$urandom_range(3) == 0}}, $urandom);
      if ($urandom_range(1) == 1) idle_cycle();
    end
    idle_cycle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/leiwand_rv32_wb_decoder.md
Name: leiwand_rv32_wb_decoder

Overview:
Parametrised Wishbone address decoder/interconnect between one leiwand_rv32 master (core) and NUM_SLAVES memory-mapped slaves (SRAM, ROM, peripherals).
- Replaces ad-hoc per-SoC stb gating and OR-merged ack/stall/data with one block.
- Routes one outstanding transaction at a time and muxes the response from the selected slave only.
- Returns an error ack for unmapped addresses and for slaves that never acknowledge (timeout).

Parameters:
MEM_WIDTH, 32, bus data/address width in bits
NUM_SLAVES, 4, number of slave channels (1..16)
SLAVE_BASES, {32'h0, 32'h0, 32'h20400000, 32'h10000000}, packed NUM_SLAVES*MEM_WIDTH byte base addresses, slave 0 in the LSBs
SLAVE_SIZES, {32'h0, 32'h0, 32'h4000, 32'h4000}, packed NUM_SLAVES*MEM_WIDTH window sizes in bytes; size 0 disables the channel
TIMEOUT_CYCLES, 255, cycles in BUSY without ack before an error ack (1..65535)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
wb_cyc  in  1  master cycle valid
wb_stb  in  1  master strobe
wb_we  in  1  master write enable
wb_addr  in  MEM_WIDTH  master byte address
wb_data_out  in  MEM_WIDTH  master write data
data_write_size  in  3  write size in bytes (1, 2, 4)
wb_ack  out  1  acknowledge to master
wb_err  out  1  error qualifier, valid only with wb_ack
wb_stall  out  1  stall to master
wb_data_in  out  MEM_WIDTH  read data to master
s_stb  out  NUM_SLAVES  per-slave strobe
s_cyc  out  NUM_SLAVES  per-slave cycle; only the selected slave's bit is high
s_we, s_addr, s_data_out, s_size  out  1/MEM_WIDTH/MEM_WIDTH/3  broadcast copies of master signals
s_ack  in  NUM_SLAVES  per-slave ack
s_stall  in  NUM_SLAVES  per-slave stall
s_data_in  in  NUM_SLAVES*MEM_WIDTH  packed per-slave read data

Behaviour:
- Decode (combinational): hit[k] = size[k]!=0 && addr >= base[k] && addr < base[k]+size[k]. Compare in MEM_WIDTH+1 bits so windows touching 2^MEM_WIDTH do not wrap. Overlapping windows: the lowest index wins.
- FSM states: IDLE, BUSY, ERR.
- Reset: state=IDLE, sel=0, timeout counter=0, wb_err=0. Asynchronous to clk; forces IDLE even mid-transaction; no ack is issued for an aborted transaction.
- IDLE, wb_cyc&&wb_stb with a hit on k:
  - s_stall[k]=1: wb_stall=1, s_stb[k]=1, stay IDLE.
  - Otherwise: s_stb[k]=1, wb_stall=0, latch sel=k, clear counter, go BUSY.
- IDLE, wb_cyc&&wb_stb with no hit: wb_stall=0 (request accepted), no s_stb asserted, go ERR.
- IDLE with no request: all outputs 0.
- BUSY:
  - wb_stall=1; s_stb=0; s_cyc[sel]=1.
  - wb_ack = s_ack[sel], combinational, zero added latency.
  - wb_data_in = s_data_in[sel] while s_ack[sel]=1, else 0.
  - Acks from non-selected slaves are ignored.
  - Next state: s_ack[sel] -> IDLE. Else counter==TIMEOUT_CYCLES-1 -> ERR. Else counter increments.
- ERR: wb_ack=1, wb_err=1, wb_data_in=0, wb_stall=1 for exactly one cycle, then IDLE. Error ack follows request acceptance by one cycle.
- wb_cyc dropping in BUSY: immediate return to IDLE next edge, no ack, counter cleared. A same-cycle s_ack is still forwarded.
- Back-to-back: a new request is decoded in the cycle after an ack, so steady-state throughput is one transaction per two cycles plus slave latency.

Optional Feature:
LEIWAND_WB_DECODER_STATS_EN
- Defined: adds output err_count (16 bits), a saturating count of error acks (unmapped plus timeout). Reset 0; holds at 16'hFFFF.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Read at 0x10000010, slave 0 acks 2 cycles after stb with data 0xDEADBEEF -> s_stb[0] pulses one cycle; wb_ack=1 with wb_data_in=0xDEADBEEF, wb_err=0; s_stb[1]=0 throughout.
- Write at 0x20400004, s_stall[1] high 3 cycles -> wb_stall=1 for 3 cycles; accepted on cycle 4; s_we=1 and s_data_out broadcast; ack forwarded.
- Read at 0x30000000 (unmapped) -> no s_stb; one cycle later wb_ack=1, wb_err=1, wb_data_in=0; with STATS_EN, err_count=1.
- Read at 0x10000000 with slave 0 never acking, TIMEOUT_CYCLES=8 -> wb_ack=wb_err=1 exactly 9 cycles after acceptance; next request accepted normally.
- Spurious s_ack[1]=1 with data 0x12345678 while BUSY on slave 0 -> wb_ack stays 0, wb_data_in=0.
- reset pulsed (not clock-aligned) mid-BUSY, then slave 0 acks -> state IDLE, wb_ack=0; next read at 0x10000008 completes normally.
